ld_st_buffer_issue: RTL and testbench
=====================================

# ld_st_buffer_issue

In-order load/store buffer that drives the data-memory unit in the SSOOO core. It accepts load and store micro-ops from dispatch and snoops the CDB for pending base and data operands. It issues at most one memory request per cycle from the FIFO head, presenting the enables, address, data, ROB tag and raw address operands that the memory unit consumes. Stores issue only at ROB commit; loads issue once their base operand is ready.

## Interface
- BUFFER_SIZE_bits, 4, log2 of entry count (16 entries)
- ROB_SIZE_bits, 4, ROB tag width minus 1; tags are ROB_SIZE_bits+1 bits; tag 0 = "operand ready, no tag"
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-low reset
- flush  in  1  mispredict flush; empties buffer next edge
- alloc_valid  in  1  dispatch writes a new entry this cycle
- alloc_is_store  in  1  1 = store, 0 = load
- alloc_ROBEN  in  ROB_SIZE_bits+1  ROB tag of the micro-op
- alloc_ROBEN1 / alloc_ROBEN1_VAL  in  ROB_SIZE_bits+1 / 32  base tag (0 = ready) and base value
- alloc_ROBEN2 / alloc_ROBEN2_VAL  in  ROB_SIZE_bits+1 / 32  store-data tag and value (ignored for loads)
- alloc_Immediate  in  32  sign-extended offset
- CDB_valid, CDB_ROBEN, CDB_VAL  in  1 / ROB_SIZE_bits+1 / 32  result broadcast
- commit_valid, commit_ROBEN  in  1 / ROB_SIZE_bits+1  ROB head retiring this cycle
- full  out  1  registered; count == 2^BUFFER_SIZE_bits
- ROBEN  out  ROB_SIZE_bits+1  tag of issued request
- Read_en, Write_en  out  1  one-cycle request pulses, mutually exclusive
- address  out  32  ROBEN1_VAL + Immediate
- data  out  32  store data (ROBEN2_VAL)
- LdStB_MEMU_ROBEN1_VAL, LdStB_MEMU_Immediate  out  32  raw operands for the memory unit's range check

## Operation
- Circular FIFO: head, tail pointers BUFFER_SIZE_bits wide; count BUFFER_SIZE_bits+1 wide. Per-entry fields: busy, is_store, ROBEN, ROBEN1, ROBEN1_VAL, ROBEN2, ROBEN2_VAL, Immediate.
- Allocation: if alloc_valid && !full, write entry at tail, tail+1 mod 2^N. If alloc_valid && full, the request is dropped and no state changes; dispatch must stall on full.
- Snoop: each busy entry with ROBEN1 == CDB_ROBEN != 0 and CDB_valid loads ROBEN1_VAL and clears ROBEN1. ROBEN2 is handled the same way.
- Same-cycle allocate + CDB match: the allocated entry captures CDB_VAL directly and its tag is written 0.
- Issue condition, head entry only:
  - Load: ROBEN1 == 0.
  - Store: ROBEN1 == 0 && ROBEN2 == 0 && commit_valid && commit_ROBEN == entry ROBEN.
- Issue: outputs are registered from the head entry, head advances, the entry's busy is cleared.
  - address = ROBEN1_VAL + Immediate, modulo 2^32, no overflow flag.
  - Range checking is left to the memory unit.
- Operands are read from the entry as stored at the start of the cycle. A CDB value arriving in the issue cycle makes the head eligible on the next cycle, not the current one.
- Count update: +1 on accepted alloc, -1 on issue. Both together leave count unchanged, and full is recomputed from the new count.
- Flush: all busy cleared, head = tail = count = 0, pending outputs are not asserted the following cycle. Flush has priority over alloc and issue in the same cycle.

## Timing
- Reset (rst == 0 at posedge): full=0, Read_en=0, Write_en=0, ROBEN=0, address=0, data=0, LdStB_MEMU_ROBEN1_VAL=0, LdStB_MEMU_Immediate=0; buffer empty.
- Reset mid-operation discards all entries; no request is emitted in the cycle after reset.
- Issue latency: a load allocated with ROBEN1 = 0 at edge N becomes head-eligible at edge N+1, and Read_en is high from edge N+1 to edge N+2.
- The memory unit samples on negedge in the same cycle Read_en/Write_en is high and returns MEMU_ROBEN/MEMU_Result at that negedge.
- Read_en/Write_en are high exactly one cycle per request; at most one request per cycle; requests are strictly in allocation order.
- Wrap-around: pointers roll over from 2^N-1 to 0 with no bubble.

## Test plan
- Reset then load alloc (ROBEN=3, ROBEN1=0, VAL=100, Imm=4) -> next cycle Read_en=1, address=104, ROBEN=3, LdStB_MEMU_ROBEN1_VAL=100, LdStB_MEMU_Immediate=4.
- Store alloc (ROBEN=5, ROBEN2=7 pending), CDB(7, 0xAB), commit(5) -> Write_en=1, data=0xAB, only in the cycle after commit; no Write_en before commit.
- Fill 16 entries with blocked base tags -> full=1, 17th alloc dropped. Release via CDB -> 16 Read_en pulses in order, full falls after the first issue, pointers wrap.
- Alloc with ROBEN1=9 while CDB(9, 50) is on the same cycle, Imm=-2 -> address=48 next cycle.
- Flush with 5 entries and head ready -> no Read_en/Write_en next cycle, full=0, subsequent alloc issues normally from slot 0.
- rst low during a pending store -> all outputs 0, the store never issues.

Source files
------------

// File: rtl/ld_st_buffer_issue.sv
// In-order load/store buffer: queues memory micro-ops from dispatch, snoops the CDB
// for base/data operands and issues one registered request per cycle from the head.
module ld_st_buffer_issue #(
  parameter int BUFFER_SIZE_bits = 4,
  parameter int ROB_SIZE_bits    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic                     alloc_is_store,
  input  logic [ROB_SIZE_bits:0]   alloc_ROBEN,
  input  logic [ROB_SIZE_bits:0]   alloc_ROBEN1,
  input  logic [31:0]              alloc_ROBEN1_VAL,
  input  logic [ROB_SIZE_bits:0]   alloc_ROBEN2,
  input  logic [31:0]              alloc_ROBEN2_VAL,
  input  logic [31:0]              alloc_Immediate,
  input  logic                     CDB_valid,
  input  logic [ROB_SIZE_bits:0]   CDB_ROBEN,
  input  logic [31:0]              CDB_VAL,
  input  logic                     commit_valid,
  input  logic [ROB_SIZE_bits:0]   commit_ROBEN,
  output logic                     full,
  output logic [ROB_SIZE_bits:0]   ROBEN,
  output logic                     Read_en,
  output logic                     Write_en,
  output logic [31:0]              address,
  output logic [31:0]              data,
  output logic [31:0]              LdStB_MEMU_ROBEN1_VAL,
  output logic [31:0]              LdStB_MEMU_Immediate
);

  localparam int DEPTH = 1 << BUFFER_SIZE_bits;
  localparam int TW    = ROB_SIZE_bits + 1;
  localparam logic [BUFFER_SIZE_bits:0] FULL_COUNT = (BUFFER_SIZE_bits + 1)'(DEPTH);

  typedef struct packed {
    logic          is_store;
    logic [TW-1:0] roben;
    logic [TW-1:0] roben1;
    logic [31:0]   roben1_val;
    logic [TW-1:0] roben2;
    logic [31:0]   roben2_val;
    logic [31:0]   immediate;
  } entry_t;

  entry_t                      buf_q [DEPTH];
  logic [DEPTH-1:0]            busy_q;
  logic [BUFFER_SIZE_bits-1:0] head_q, tail_q;
  logic [BUFFER_SIZE_bits:0]   count_q, count_next;

  entry_t head_e, alloc_e;
  logic   alloc_ok, issue, cdb_hit;

  always_comb begin
    head_e   = buf_q[head_q];
    alloc_ok = alloc_valid && !full;
    cdb_hit  = CDB_valid && (CDB_ROBEN != '0);

    // Operands come from the entry as stored at cycle start; a CDB hit this cycle
    // only makes the head eligible next cycle.
    issue = busy_q[head_q] && (head_e.roben1 == '0) &&
            (!head_e.is_store ||
             ((head_e.roben2 == '0) && commit_valid && (commit_ROBEN == head_e.roben)));

    alloc_e            = '0;
    alloc_e.is_store   = alloc_is_store;
    alloc_e.roben      = alloc_ROBEN;
    alloc_e.roben1     = alloc_ROBEN1;
    alloc_e.roben1_val = alloc_ROBEN1_VAL;
    alloc_e.roben2     = alloc_ROBEN2;
    alloc_e.roben2_val = alloc_ROBEN2_VAL;
    alloc_e.immediate  = alloc_Immediate;
    if (cdb_hit && (alloc_ROBEN1 == CDB_ROBEN)) begin
      alloc_e.roben1     = '0;
      alloc_e.roben1_val = CDB_VAL;
    end
    if (cdb_hit && (alloc_ROBEN2 == CDB_ROBEN)) begin
      alloc_e.roben2     = '0;
      alloc_e.roben2_val = CDB_VAL;
    end

    count_next = count_q;
    if (alloc_ok && !issue)      count_next = count_q + 1'b1;
    else if (!alloc_ok && issue) count_next = count_q - 1'b1;
  end

  // NOTE: entry payload has no reset; busy_q alone decides whether a slot is live,
  // so the storage can map onto plain registers or RAM without a clear path.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && cdb_hit) begin
        if (buf_q[i].roben1 == CDB_ROBEN) begin
          buf_q[i].roben1     <= '0;
          buf_q[i].roben1_val <= CDB_VAL;
        end
        if (buf_q[i].roben2 == CDB_ROBEN) begin
          buf_q[i].roben2     <= '0;
          buf_q[i].roben2_val <= CDB_VAL;
        end
      end
    end
    if (alloc_ok) buf_q[tail_q] <= alloc_e;
  end

  // Flush shares the reset path for control state and wins over alloc/issue.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full    <= 1'b0;
    end else begin
      if (alloc_ok) begin
        busy_q[tail_q] <= 1'b1;
        tail_q         <= tail_q + 1'b1;
      end
      if (issue) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      count_q <= count_next;
      full    <= (count_next == FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      Read_en               <= 1'b0;
      Write_en              <= 1'b0;
      ROBEN                 <= '0;
      address               <= '0;
      data                  <= '0;
      LdStB_MEMU_ROBEN1_VAL <= '0;
      LdStB_MEMU_Immediate  <= '0;
    end else begin
      Read_en  <= 1'b0;
      Write_en <= 1'b0;
      if (!flush && issue) begin
        Read_en               <= !head_e.is_store;
        Write_en              <= head_e.is_store;
        ROBEN                 <= head_e.roben;
        address               <= head_e.roben1_val + head_e.immediate;
        data                  <= head_e.roben2_val;
        LdStB_MEMU_ROBEN1_VAL <= head_e.roben1_val;
        LdStB_MEMU_Immediate  <= head_e.immediate;
      end
    end
  end

endmodule

// File: tb/tb_ld_st_buffer_issue.sv
// Directed bench for ld_st_buffer_issue: hand-computed vectors for issue latency,
// store commit gating, full/wrap, same-cycle CDB capture, flush and reset.
module tb_ld_st_buffer_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_valid, alloc_is_store;
  logic [4:0]  alloc_ROBEN, alloc_ROBEN1, alloc_ROBEN2;
  logic [31:0] alloc_ROBEN1_VAL, alloc_ROBEN2_VAL, alloc_Immediate;
  logic        CDB_valid;
  logic [4:0]  CDB_ROBEN;
  logic [31:0] CDB_VAL;
  logic        commit_valid;
  logic [4:0]  commit_ROBEN;
  logic        full, Read_en, Write_en;
  logic [4:0]  ROBEN;
  logic [31:0] address, data, LdStB_MEMU_ROBEN1_VAL, LdStB_MEMU_Immediate;

  int n_vec = 0;
  int n_err = 0;

  ld_st_buffer_issue #(.BUFFER_SIZE_bits(4), .ROB_SIZE_bits(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
    .alloc_ROBEN(alloc_ROBEN), .alloc_ROBEN1(alloc_ROBEN1),
    .alloc_ROBEN1_VAL(alloc_ROBEN1_VAL), .alloc_ROBEN2(alloc_ROBEN2),
    .alloc_ROBEN2_VAL(alloc_ROBEN2_VAL), .alloc_Immediate(alloc_Immediate),
    .CDB_valid(CDB_valid), .CDB_ROBEN(CDB_ROBEN), .CDB_VAL(CDB_VAL),
    .commit_valid(commit_valid), .commit_ROBEN(commit_ROBEN),
    .full(full), .ROBEN(ROBEN), .Read_en(Read_en), .Write_en(Write_en),
    .address(address), .data(data),
    .LdStB_MEMU_ROBEN1_VAL(LdStB_MEMU_ROBEN1_VAL),
    .LdStB_MEMU_Immediate(LdStB_MEMU_Immediate)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one active edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_valid = 0; alloc_is_store = 0;
    alloc_ROBEN = 0; alloc_ROBEN1 = 0; alloc_ROBEN2 = 0;
    alloc_ROBEN1_VAL = 0; alloc_ROBEN2_VAL = 0; alloc_Immediate = 0;
    CDB_valid = 0; CDB_ROBEN = 0; CDB_VAL = 0;
    commit_valid = 0; commit_ROBEN = 0;
  endtask

  task automatic set_alloc(input logic st, input logic [4:0] rb, input logic [4:0] r1,
                           input logic [31:0] v1, input logic [4:0] r2,
                           input logic [31:0] v2, input logic [31:0] imm);
    alloc_valid = 1; alloc_is_store = st; alloc_ROBEN = rb;
    alloc_ROBEN1 = r1; alloc_ROBEN1_VAL = v1;
    alloc_ROBEN2 = r2; alloc_ROBEN2_VAL = v2; alloc_Immediate = imm;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_full"}, {31'd0, full}, 32'd0);
    check({tag, "_rd"}, {31'd0, Read_en}, 32'd0);
    check({tag, "_wr"}, {31'd0, Write_en}, 32'd0);
    check({tag, "_roben"}, {27'd0, ROBEN}, 32'd0);
    check({tag, "_addr"}, address, 32'd0);
    check({tag, "_data"}, data, 32'd0);
    check({tag, "_r1val"}, LdStB_MEMU_ROBEN1_VAL, 32'd0);
    check({tag, "_imm"}, LdStB_MEMU_Immediate, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 0;
    step(); step();
    check_all_zero("reset");
    rst = 1;

    // Ready load: Read_en one cycle after allocation, address = 100 + 4.
    set_alloc(0, 5'd3, 5'd0, 32'd100, 5'd0, 32'd0, 32'd4);
    step();
    idle_inputs();
    check("ld_lat_early", {31'd0, Read_en}, 32'd0);
    step();
    check("ld_rd", {31'd0, Read_en}, 32'd1);
    check("ld_wr", {31'd0, Write_en}, 32'd0);
    check("ld_addr", address, 32'd104);
    check("ld_roben", {27'd0, ROBEN}, 32'd3);
    check("ld_r1val", LdStB_MEMU_ROBEN1_VAL, 32'd100);
    check("ld_imm", LdStB_MEMU_Immediate, 32'd4);
    step();
    check("ld_pulse_end", {31'd0, Read_en}, 32'd0);

    // Store waits for its data tag and then for commit.
    set_alloc(1, 5'd5, 5'd0, 32'h1000, 5'd7, 32'd0, 32'd0);
    step();
    idle_inputs();
    step();
    check("st_wait_data", {31'd0, Write_en}, 32'd0);
    CDB_valid = 1; CDB_ROBEN = 5'd7; CDB_VAL = 32'hAB;
    step();
    idle_inputs();
    step(); step();
    check("st_wait_commit", {31'd0, Write_en}, 32'd0);
    commit_valid = 1; commit_ROBEN = 5'd5;
    step();
    idle_inputs();
    check("st_wr", {31'd0, Write_en}, 32'd1);
    check("st_rd", {31'd0, Read_en}, 32'd0);
    check("st_data", data, 32'hAB);
    check("st_addr", address, 32'h1000);
    check("st_roben", {27'd0, ROBEN}, 32'd5);
    step();
    check("st_pulse_end", {31'd0, Write_en}, 32'd0);

    // Fill all 16 slots (head sits at slot 2, so pointers wrap) with blocked loads.
    for (int i = 0; i < 16; i++) begin
      set_alloc(0, 5'(16 + i), 5'd10, 32'd0, 5'd0, 32'd0, 32'(i * 4));
      step();
    end
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_no_rd", {31'd0, Read_en}, 32'd0);
    set_alloc(0, 5'd1, 5'd0, 32'h9999, 5'd0, 32'd0, 32'd0);
    step();
    idle_inputs();
    check("drop_full", {31'd0, full}, 32'd1);
    CDB_valid = 1; CDB_ROBEN = 5'd10; CDB_VAL = 32'h200;
    step();
    idle_inputs();
    check("release_no_rd_yet", {31'd0, Read_en}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("drain%0d_rd", i), {31'd0, Read_en}, 32'd1);
      check($sformatf("drain%0d_roben", i), {27'd0, ROBEN}, 32'(16 + i));
      check($sformatf("drain%0d_addr", i), address, 32'h200 + 32'(i * 4));
      if (i == 0) check("drain_full_fall", {31'd0, full}, 32'd0);
    end
    step();
    check("dropped_not_issued", {31'd0, Read_en}, 32'd0);

    // Same-cycle allocate and CDB hit on the base tag, negative offset.
    set_alloc(0, 5'd2, 5'd9, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFFE);
    CDB_valid = 1; CDB_ROBEN = 5'd9; CDB_VAL = 32'd50;
    step();
    idle_inputs();
    step();
    check("bypass_rd", {31'd0, Read_en}, 32'd1);
    check("bypass_addr", address, 32'd48);
    check("bypass_r1val", LdStB_MEMU_ROBEN1_VAL, 32'd50);
    check("bypass_imm", LdStB_MEMU_Immediate, 32'hFFFF_FFFE);
    step();

    // Flush five entries while the head is ready to issue.
    for (int i = 0; i < 5; i++) begin
      set_alloc(0, 5'(20 + i), 5'd12, 32'd0, 5'd0, 32'd0, 32'd0);
      step();
    end
    idle_inputs();
    CDB_valid = 1; CDB_ROBEN = 5'd12; CDB_VAL = 32'h40;
    step();
    idle_inputs();
    flush = 1;
    step();
    idle_inputs();
    check("flush_rd", {31'd0, Read_en}, 32'd0);
    check("flush_wr", {31'd0, Write_en}, 32'd0);
    check("flush_full", {31'd0, full}, 32'd0);
    step();
    check("flush_rd_after", {31'd0, Read_en}, 32'd0);
    set_alloc(0, 5'd6, 5'd0, 32'd7, 5'd0, 32'd0, 32'd1);
    step();
    idle_inputs();
    step();
    check("post_flush_rd", {31'd0, Read_en}, 32'd1);
    check("post_flush_addr", address, 32'd8);
    check("post_flush_roben", {27'd0, ROBEN}, 32'd6);
    step();

    // Reset with a ready store pending: it must never issue.
    set_alloc(1, 5'd4, 5'd0, 32'h80, 5'd0, 32'h55, 32'd0);
    step();
    idle_inputs();
    rst = 0;
    step();
    check_all_zero("midreset");
    rst = 1;
    commit_valid = 1; commit_ROBEN = 5'd4;
    step();
    check("midreset_no_wr0", {31'd0, Write_en}, 32'd0);
    step();
    idle_inputs();
    check("midreset_no_wr1", {31'd0, Write_en}, 32'd0);
    check("midreset_no_rd", {31'd0, Read_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
